// File: rtl/sysbus_pkg.sv
// Shared sysbus definitions: tag layout, transaction constants and responder states.
// Used by both the memory responder and the initiator.
package sysbus_pkg;

  localparam int unsigned WORD_W         = 64;
  localparam int unsigned TAG_W          = 13;
  localparam int unsigned TAG_RW_BIT     = 12;
  localparam int unsigned TAG_TYPE_LSB   = 8;
  localparam int unsigned TAG_TYPE_W     = 4;
  localparam int unsigned TAG_ID_W       = 8;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned BEAT_IDX_W     = $clog2(BEATS_PER_LINE);
  localparam int unsigned WORD_SEL_LSB   = 3;
  localparam int unsigned LINE_SEL_LSB   = 6;

  localparam logic                  TAG_READ    = 1'b1;
  localparam logic                  TAG_WRITE   = 1'b0;
  localparam logic [TAG_TYPE_W-1:0] TYPE_MEMORY = 4'd1;

  typedef struct packed {
    logic                  rw;
    logic [TAG_TYPE_W-1:0] kind;
    logic [TAG_ID_W-1:0]   id;
  } sysbus_tag_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WDATA,
    RLAT,
    RBURST
  } resp_state_e;

  function automatic logic tag_is_read(logic [TAG_W-1:0] t);
    return t[TAG_RW_BIT] == TAG_READ;
  endfunction

  function automatic logic tag_is_memory(logic [TAG_W-1:0] t);
    return t[TAG_TYPE_LSB +: TAG_TYPE_W] == TYPE_MEMORY;
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Request/response handshake between a sysbus initiator (master) and responder (slave).
interface sysbus_mem_responder_if;

  logic                                reqcyc;
  logic [sysbus_pkg::WORD_W-1:0]       req;
  sysbus_pkg::sysbus_tag_t             reqtag;
  logic                                reqack;
  logic                                respcyc;
  logic [sysbus_pkg::WORD_W-1:0]       resp;
  sysbus_pkg::sysbus_tag_t             resptag;
  logic                                respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/sysbus_mem_array.sv
// Line storage: MEM_LINES lines of 8 x 64-bit words, synchronous write, combinational read.
// Contents are deliberately not reset.
module sysbus_mem_array
  import sysbus_pkg::*;
#(
  parameter  int unsigned MEM_LINES = 256,
  localparam int unsigned DEPTH     = MEM_LINES * BEATS_PER_LINE,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: accepts one line read or write at a time, returns
// read lines critical-word first with per-beat respack flow control.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int unsigned LINE_W = $clog2(MEM_LINES);
  localparam int unsigned ADDR_W = LINE_W + BEAT_IDX_W;
  localparam int unsigned LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_LINE - 1);

  resp_state_e            state_q, state_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [BEAT_IDX_W-1:0]  beat_q, beat_d;
  logic [BEAT_IDX_W-1:0]  start_q, start_d;
  logic [LINE_W-1:0]      line_q, line_d;
  sysbus_tag_t            tag_q, tag_d;
  logic                   reqack_q, reqack_d;
  logic                   respcyc_q, respcyc_d;
  logic [WORD_W-1:0]      resp_q, resp_d;
  sysbus_tag_t            resptag_q, resptag_d;

  logic                   wr_en_c;
  logic [BEAT_IDX_W-1:0]  wr_word_c, rd_word_c;
  logic [WORD_W-1:0]      rd_data_c;

  // Write uses the current beat; read looks ahead so resp is registered with the beat.
  assign wr_word_c = start_q + beat_q;
  assign rd_word_c = start_d + beat_d;

  sysbus_mem_array #(.MEM_LINES(MEM_LINES)) u_array (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   ({line_q, wr_word_c}),
    .wr_data   (bus.req),
    .rd_addr   ({line_d, rd_word_c}),
    .rd_data_c (rd_data_c)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    start_d   = start_q;
    line_d    = line_q;
    tag_d     = tag_q;
    wr_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.reqcyc) begin
          line_d  = bus.req[LINE_SEL_LSB +: LINE_W];
          start_d = bus.req[WORD_SEL_LSB +: BEAT_IDX_W];
          tag_d   = bus.reqtag;
          beat_d  = '0;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!tag_is_read(tag_q)) begin
          state_d = WDATA;
        end else if (RD_LATENCY <= 1) begin
          state_d = RBURST;
        end else begin
          lat_d   = LAT_W'(RD_LATENCY - 1);
          state_d = RLAT;
        end
      end
      RLAT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_d == '0) begin
          state_d = RBURST;
        end
      end
      WDATA: begin
        if (bus.reqcyc) begin
          wr_en_c = tag_is_memory(tag_q);
          beat_d  = beat_q + BEAT_IDX_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      RBURST: begin
        if (respcyc_q && bus.respack) begin
          beat_d = beat_q + BEAT_IDX_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    reqack_d  = (state_d == ACK);
    respcyc_d = (state_d == RBURST);
    resp_d    = '0;
    resptag_d = '0;
    if (state_d == RBURST) begin
      resp_d    = tag_is_memory(tag_d) ? rd_data_c : {WORD_W{1'b1}};
      resptag_d = tag_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      start_q   <= '0;
      line_q    <= '0;
      tag_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      start_q   <= start_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = respcyc_q;
  assign bus.resp    = resp_q;
  assign bus.resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: table of line reads against a
// bench memory model, plus stall and mid-burst reset sequences.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int unsigned MEM_LINES  = 256;
  localparam int unsigned RD_LATENCY = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sysbus_mem_responder_if bus();

  sysbus_mem_responder #(.MEM_LINES(MEM_LINES), .RD_LATENCY(RD_LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    sysbus_tag_t tag;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  kind;
    logic [7:0]  id;
    logic [2:0]  exp_first;
    logic        exp_ones;
  } rd_vec_t;

  int          tests = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  logic [63:0] model [int];
  logic        man_mode = 1'b0;
  logic        man_ack  = 1'b0;

  always_comb bus.respack = man_mode ? man_ack : bus.respcyc;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic sysbus_tag_t mk_tag(logic rw, logic [3:0] kind, logic [7:0] id);
    sysbus_tag_t t;
    t.rw   = rw;
    t.kind = kind;
    t.id   = id;
    return t;
  endfunction

  function automatic int word_key(logic [63:0] addr, logic [2:0] word);
    return int'(addr[6 +: 8]) * 8 + int'(word);
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (!reset) begin
      if (bus.respcyc && bus.respack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(bus.respcyc), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.resp, e.data);
          check("beat_tag", 64'(bus.resptag), 64'(e.tag));
        end
      end else if (!bus.respcyc) begin
        check("idle_resp", bus.resp, 64'(0));
        check("idle_resptag", 64'(bus.resptag), 64'(0));
      end
    end
  end

  // Request phase; returns at the cycle after the ack, with reqcyc dropped.
  task automatic issue(input logic [63:0] addr, input sysbus_tag_t tag);
    @(posedge clk); #1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = tag;
    @(posedge clk);
    @(negedge clk);
    check("reqack_latency", 64'(bus.reqack), 64'(1));
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [3:0] kind,
                          input logic [7:0] id, input logic [63:0] base);
    issue(addr, mk_tag(TAG_WRITE, kind, id));
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        bus.reqcyc = 1'b0;
        bus.req    = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        check("wr_no_resp", 64'(bus.respcyc), 64'(0));
        @(posedge clk); #1;
      end
      bus.reqcyc = 1'b1;
      bus.req    = base + 64'(k);
      @(negedge clk);
      check("wr_no_resp", 64'(bus.respcyc), 64'(0));
      @(posedge clk); #1;
      if (kind == TYPE_MEMORY) model[word_key(addr, addr[5:3] + 3'(k))] = base + 64'(k);
    end
    bus.reqcyc = 1'b0;
  endtask

  task automatic do_read(input rd_vec_t v, input logic stall);
    sysbus_tag_t tag;
    logic [63:0] ew [8];
    int          n;
    int          b;
    int          waitc;
    int          budget;
    logic        prev_acc;
    tag = mk_tag(TAG_READ, v.kind, v.id);
    for (int k = 0; k < 8; k++) begin
      ew[k] = v.exp_ones ? 64'hFFFF_FFFF_FFFF_FFFF : model[word_key(v.addr, v.exp_first + 3'(k))];
      exp_q.push_back('{data: ew[k], tag: tag});
    end
    man_mode = stall;
    man_ack  = 1'b0;
    issue(v.addr, tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("reqack_single", 64'(bus.reqack), 64'(0));
    end while (!bus.respcyc && n < 50);
    check("first_beat_latency", 64'(n), 64'(RD_LATENCY));
    if (stall) begin
      b = 0; waitc = 0; budget = 200; prev_acc = 1'b0;
      while (b < 8 && budget > 0) begin
        @(posedge clk); #1;
        budget--;
        if (prev_acc) begin
          b++;
          waitc = 0;
        end
        if (b == 8) break;
        if (bus.respcyc && (b == 2 || b == 3) && waitc < 3) begin
          man_ack = 1'b0;
          waitc++;
          check("stall_hold_data", bus.resp, ew[b]);
          check("stall_hold_tag", 64'(bus.resptag), 64'(tag));
          prev_acc = 1'b0;
        end else begin
          man_ack  = 1'b1;
          prev_acc = bus.respcyc;
        end
      end
      man_ack = 1'b0;
      check("stall_beats_accepted", 64'(b), 64'(8));
    end else begin
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    end
    check("read_all_beats", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(negedge clk);
    check("post_burst_idle", 64'(bus.respcyc), 64'(0));
    man_mode = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    rd_vec_t vecs [6];
    rd_vec_t v;
    sysbus_tag_t rtag;
    int n;

    vecs[0] = '{addr: 64'h1000,        kind: 4'd1, id: 8'h11, exp_first: 3'd0, exp_ones: 1'b0};
    vecs[1] = '{addr: 64'h1028,        kind: 4'd1, id: 8'h22, exp_first: 3'd5, exp_ones: 1'b0};
    vecs[2] = '{addr: 64'h2000,        kind: 4'd1, id: 8'h33, exp_first: 3'd0, exp_ones: 1'b0};
    vecs[3] = '{addr: 64'hA0000,       kind: 4'd2, id: 8'h44, exp_first: 3'd0, exp_ones: 1'b1};
    vecs[4] = '{addr: 64'h1_0000_1038, kind: 4'd1, id: 8'h55, exp_first: 3'd7, exp_ones: 1'b0};
    vecs[5] = '{addr: 64'h20C0,        kind: 4'd1, id: 8'h66, exp_first: 3'd0, exp_ones: 1'b0};

    bus.reqcyc = 1'b0;
    bus.req    = '0;
    bus.reqtag = '0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reqack", 64'(bus.reqack), 64'(0));
    check("rst_respcyc", 64'(bus.respcyc), 64'(0));
    check("rst_resp", bus.resp, 64'(0));
    check("rst_resptag", 64'(bus.resptag), 64'(0));
    #1 reset = 1'b0;

    do_write(64'h1000, 4'd1, 8'h01, 64'h1111_0000_0000_0000);
    do_write(64'h2000, 4'd1, 8'h02, 64'hA0);
    do_write(64'h20E8, 4'd1, 8'h03, 64'hB0);
    do_write(64'h1000, 4'd3, 8'h04, 64'hDEAD_0000);

    for (int i = 0; i < 6; i++) do_read(vecs[i], 1'b0);

    v = '{addr: 64'h6010, kind: 4'd1, id: 8'h77, exp_first: 3'd2, exp_ones: 1'b0};
    do_read(v, 1'b0);
    do_read(vecs[0], 1'b1);

    // Reset while beat 4 of a read is on the bus.
    rtag = mk_tag(TAG_READ, 4'd1, 8'h88);
    for (int k = 0; k < 8; k++) exp_q.push_back('{data: model[word_key(64'h1000, 3'(k))], tag: rtag});
    issue(64'h1000, rtag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.respcyc && n < 50);
    check("rst_seq_burst_start", 64'(bus.respcyc), 64'(1));
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midburst_rst_respcyc", 64'(bus.respcyc), 64'(0));
    check("midburst_rst_reqack", 64'(bus.reqack), 64'(0));
    check("midburst_rst_resp", bus.resp, 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    do_read(vecs[1], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameters SHALL be: MEM_LINES, 256, number of 64-byte lines stored; RD_LATENCY, 4, cycles from reqack to first read beat (min 1).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqcyc  input  1  initiator request valid, also write-data beat valid.
REQ-005 req  input  64  request address, or write-data beat after a write ack.
REQ-006 reqtag  input  13  [12] 1=READ/0=WRITE; [11:8] type, MEMORY=1, MMIO=other; [7:0] id.
REQ-007 reqack  output  1  one-cycle request acceptance pulse.
REQ-008 respcyc  output  1  read-data beat valid.
REQ-009 resp  output  64  read-data beat.
REQ-010 resptag  output  13  reqtag captured for the request being answered.
REQ-011 respack  input  1  initiator accepts the current beat.

Function
REQ-012 FSM states SHALL be IDLE, ACK, WDATA, RLAT, RBURST.
REQ-013 IDLE with reqcyc=1: capture req and reqtag at that edge; go to ACK; reqack=1 for exactly the ACK cycle.
REQ-014 reqcyc while not in IDLE SHALL be ignored: no ack, no capture. This includes the initiator's trailing reqcyc in the ACK cycle.
REQ-015 ACK, READ request: go to RLAT with counter = RD_LATENCY-1. RLAT decrements each cycle and enters RBURST when the counter is 0.
REQ-016 RBURST SHALL drive 8 beats, respcyc=1 and resptag=captured tag. Beat order is critical-word first: word index starts at captured req[5:3] and increments mod 8.
REQ-017 A beat SHALL advance only on a cycle with respcyc=1 and respack=1. With respack=0, resp and resptag hold stable.
REQ-018 After the 8th accepted beat the FSM SHALL go to IDLE, with respcyc=0 in the following cycle.
REQ-019 ACK, WRITE request: go to WDATA. Each WDATA cycle with reqcyc=1 stores req into word (start+k) mod 8 of the line, where k is the beat count 0..7. After 8 beats go to IDLE. Writes produce no response.
REQ-020 Line index SHALL be req[6 +: log2(MEM_LINES)]. Upper address bits are ignored, so out-of-range addresses wrap.
REQ-021 Non-MEMORY type requests SHALL be acked normally. Their reads return 64'hFFFF_FFFF_FFFF_FFFF on every beat. Their writes are consumed and discarded.
REQ-022 Read data SHALL reflect all writes completed before the read's ACK cycle.
REQ-023 Outside RBURST: respcyc=0, resp=0, resptag=0.

Reset
REQ-024 Reset asserted SHALL force state IDLE, reqack=0, respcyc=0, resp=0, resptag=0, and clear counters and captured request, regardless of the current state.
REQ-025 Reset mid-burst or mid-write SHALL abandon the transaction. Memory contents are not reset; words already written stay written.
REQ-026 After reset deasserts, the first reqcyc sampled in IDLE SHALL be accepted per REQ-013.

Structure
REQ-027 Shared package sysbus_pkg SHALL hold: tag field positions, READ/WRITE and MEMORY constants, BEATS_PER_LINE=8, and the responder state enum. The Core initiator uses the same package.
REQ-028 Storage SHALL be one sub-module, sysbus_mem_array: MEM_LINES*8 words of 64 bits, one synchronous write port, one read port. Read-port latency is absorbed within RLAT.

Verification
REQ-029 Read line 0x1000 (pre-loaded word i = 64'h1111_0000_0000_0000+i), respack tied to respcyc: reqack 1 cycle after reqcyc; first beat RD_LATENCY cycles after reqack; 8 consecutive beats, words 0..7.
REQ-030 Read addr 0x1028: beat order is words 5,6,7,0,1,2,3,4.
REQ-031 Write line 0x2000 with beats 0xA0..0xA7, then read it back: no respcyc during the write; readback returns 0xA0..0xA7.
REQ-032 Read with respack low on beats 2 and 3 for 3 cycles each: resp holds each word while stalled; exactly 8 distinct beats accepted.
REQ-033 Assert reset during beat 4: respcyc=0 and reqack=0 immediately; a new read then completes with correct data.
REQ-034 MMIO read (type=2) at 0xA0000: acked; 8 beats of all-ones; resptag equals the request tag.
